// File: rtl/circuit5_operand_loader_pkg.sv
// Shared types and defaults for the Circuit5 operand loader.
// The state encoding is fixed so that external probes can decode it.
package circuit5_operand_loader_pkg;

  localparam int unsigned DEFAULT_DATAWIDTH = 64;
  localparam int unsigned DEFAULT_LATENCY   = 2;
  localparam int unsigned DEFAULT_CNTW      = 16;
  localparam int unsigned STATE_W           = 3;

  typedef enum logic [STATE_W-1:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_C    = 3'd2,
    S_HOLD = 3'd3,
    S_RES  = 3'd4
  } state_e;

  // States in which a new operand word may be taken.
  function automatic logic is_load_state(input state_e s);
    return (s == S_A) || (s == S_B) || (s == S_C);
  endfunction

  // States in which a complete triple is parked on the datapath.
  function automatic logic is_busy_state(input state_e s);
    return (s == S_HOLD) || (s == S_RES);
  endfunction

endpackage

// File: rtl/circuit5_operand_loader_latency_timer.sv
// Loadable down-counter that flags the cycle in which the datapath
// register pipeline has settled (count == 1).
module circuit5_operand_loader_latency_timer
  import circuit5_operand_loader_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          last_q;

  // Load wins over decrement; the count saturates at zero once expired.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(LATENCY);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= (count_d == CW'(1));
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/circuit5_operand_loader.sv
// Collects a, b, c operand words from a valid/ready stream, holds them stable
// through the datapath latency, then presents a result-valid handshake.
module circuit5_operand_loader
  import circuit5_operand_loader_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int unsigned LATENCY   = DEFAULT_LATENCY,
  parameter int unsigned CNTW      = DEFAULT_CNTW
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNTW-1:0]      txn_count
);

  state_e               state_q;
  state_e               state_d;
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [DATAWIDTH-1:0] c_q;
  logic [CNTW-1:0]      txn_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 res_valid_q;

  logic                 accept;
  logic                 load_timer;
  logic                 timer_last;
  logic                 txn_done;

  assign accept = in_valid && in_ready_q;

  circuit5_operand_loader_latency_timer #(
    .LATENCY (LATENCY)
  ) u_latency_timer (
    .clk    (Clk),
    .rst_n  (Rst),
    .load_i (load_timer),
    .dec_i  (state_q == S_HOLD),
    .last_o (timer_last)
  );

  // Next-state decode; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    load_timer = 1'b0;
    txn_done   = 1'b0;
    case (state_q)
      S_A: begin
        if (accept) state_d = S_B;
      end
      S_B: begin
        if (accept) state_d = S_C;
      end
      S_C: begin
        if (accept) begin
          state_d    = S_HOLD;
          load_timer = 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_last) state_d = S_RES;
      end
      S_RES: begin
        if (res_ready) begin
          state_d  = S_A;
          txn_done = 1'b1;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      txn_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= is_load_state(state_d);
      busy_q      <= is_busy_state(state_d);
      res_valid_q <= (state_d == S_RES);
      if (accept && (state_q == S_A)) a_q <= in_data;
      if (accept && (state_q == S_B)) b_q <= in_data;
      if (accept && (state_q == S_C)) c_q <= in_data;
      if (txn_done) txn_q <= txn_q + CNTW'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_circuit5_operand_loader.sv
// Directed bench for the operand loader: default build plus a LATENCY=1, CNTW=2 build.
module tb_circuit5_operand_loader;

  logic        Clk = 1'b0;
  logic        Rst;

  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b, c;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] txn_count;

  logic [63:0] in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [63:0] a1, b1, c1;
  logic        busy1;
  logic        res_valid1;
  logic        res_ready1;
  logic [1:0]  txn_count1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  circuit5_operand_loader #(
    .DATAWIDTH (64),
    .LATENCY   (2),
    .CNTW      (16)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .txn_count (txn_count)
  );

  circuit5_operand_loader #(
    .DATAWIDTH (64),
    .LATENCY   (1),
    .CNTW      (2)
  ) dut1 (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .c         (c1),
    .busy      (busy1),
    .res_valid (res_valid1),
    .res_ready (res_ready1),
    .txn_count (txn_count1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic        gap_vld [6];
  logic [63:0] gap_dat [6];
  logic [1:0]  exp_txn1;

  initial begin
    gap_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    gap_dat = '{64'hA1, 64'hDEAD, 64'hDEAD, 64'hB1, 64'hDEAD, 64'hC1};

    Rst        = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    res_ready  = 1'b0;
    in_data1   = '0;
    in_valid1  = 1'b0;
    res_ready1 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_a", a, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    Rst = 1'b1;
    tick();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back 5, 3, 1 with in_valid held high
    in_valid = 1'b1;
    in_data  = 64'd5;
    tick();
    check("t1_a", a, 64'd5);
    check("t1_rdy_a", 64'(in_ready), 64'd1);
    in_data = 64'd3;
    tick();
    check("t1_b", b, 64'd3);
    check("t1_rdy_b", 64'(in_ready), 64'd1);
    in_data = 64'd1;
    tick();
    check("t1_c", c, 64'd1);
    check("t1_rdy_c", 64'(in_ready), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_rv0", 64'(res_valid), 64'd0);
    tick();
    check("t1_rv1", 64'(res_valid), 64'd0);
    check("t1_b_held", b, 64'd3);
    tick();
    check("t1_rv2", 64'(res_valid), 64'd1);
    check("t1_c_held", c, 64'd1);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_txn", 64'(txn_count), 64'd1);
    check("t1_rv_drop", 64'(res_valid), 64'd0);
    check("t1_busy_drop", 64'(busy), 64'd0);
    check("t1_rdy_back", 64'(in_ready), 64'd1);
    check("t1_a_after", a, 64'd5);

    // Long hold in S_RES with junk offered on the input
    send(64'h11);
    send(64'h22);
    send(64'h33);
    tick();
    tick();
    check("t2_rv", 64'(res_valid), 64'd1);
    in_valid = 1'b1;
    in_data  = 64'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_rv", 64'(res_valid), 64'd1);
      check("t2_hold_a", a, 64'h11);
      check("t2_hold_b", b, 64'h22);
      check("t2_hold_c", c, 64'h33);
    end
    check("t2_txn_hold", 64'(txn_count), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t2_txn", 64'(txn_count), 64'd2);
    check("t2_bubble_a", a, 64'h11);
    check("t2_bubble_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t2_post_a", a, 64'hFF);
    check("t2_post_b", b, 64'h22);
    send(64'h02);
    send(64'h03);
    tick();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t2_txn2", 64'(txn_count), 64'd3);

    // Gapped input stream
    for (int i = 0; i < 6; i++) begin
      in_valid = gap_vld[i];
      in_data  = gap_dat[i];
      tick();
    end
    in_valid = 1'b0;
    check("t3_a", a, 64'hA1);
    check("t3_b", b, 64'hB1);
    check("t3_c", c, 64'hC1);
    check("t3_busy", 64'(busy), 64'd1);
    tick();
    check("t3_rv1", 64'(res_valid), 64'd0);
    tick();
    check("t3_rv2", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t3_txn", 64'(txn_count), 64'd4);

    // Asynchronous reset while holding a triple
    send(64'h1);
    send(64'hAAAA);
    send(64'h3);
    check("t4_busy", 64'(busy), 64'd1);
    check("t4_b", b, 64'hAAAA);
    Rst = 1'b0;
    #2;
    check("t4_a0", a, 64'd0);
    check("t4_b0", b, 64'd0);
    check("t4_c0", c, 64'd0);
    check("t4_rv0", 64'(res_valid), 64'd0);
    check("t4_busy0", 64'(busy), 64'd0);
    check("t4_rdy0", 64'(in_ready), 64'd0);
    check("t4_txn0", 64'(txn_count), 64'd0);
    Rst = 1'b1;
    tick();
    // res_ready held high outside S_RES must be ignored
    res_ready = 1'b1;
    send(64'h7);
    send(64'h7);
    send(64'h7);
    check("t4_txn_hold", 64'(txn_count), 64'd0);
    tick();
    check("t4_rv1", 64'(res_valid), 64'd0);
    check("t4_txn_hold2", 64'(txn_count), 64'd0);
    tick();
    check("t4_rv2", 64'(res_valid), 64'd1);
    check("t4_abc", {a[15:0], b[15:0], c[15:0]}, 64'h0007_0007_0007);
    tick();
    res_ready = 1'b0;
    check("t4_txn", 64'(txn_count), 64'd1);
    check("t4_rv_drop", 64'(res_valid), 64'd0);

    // LATENCY=1, CNTW=2 build: five transactions, counter wraps
    res_ready1 = 1'b1;
    exp_txn1   = 2'd0;
    for (int t = 0; t < 5; t++) begin
      in_valid1 = 1'b1;
      in_data1  = 64'(t) + 64'h100;
      tick();
      in_data1  = 64'(t) + 64'h200;
      tick();
      in_data1  = 64'(t) + 64'h300;
      tick();
      in_valid1 = 1'b0;
      check("l1_c", c1, 64'(t) + 64'h300);
      check("l1_rv0", 64'(res_valid1), 64'd0);
      check("l1_busy", 64'(busy1), 64'd1);
      tick();
      check("l1_rv1", 64'(res_valid1), 64'd1);
      tick();
      exp_txn1 = exp_txn1 + 2'd1;
      check("l1_txn", 64'(txn_count1), 64'(exp_txn1));
      check("l1_rdy", 64'(in_ready1), 64'd1);
    end
    res_ready1 = 1'b0;
    check("l1_wrap", 64'(txn_count1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
